// File: rtl/sha1_pkg.sv
// ----------------------------------------------------------------------------
// sha1_pkg
// Shared widths and types for the sha1 arbiter slice.
//   BLOCK_W  : width of one SHA-1 message block.
//   DIGEST_W : width of a SHA-1 digest.
//   state_e  : arbiter job state.
//   max_int  : elaboration-time helper for sizing counters.
// ----------------------------------------------------------------------------
package sha1_pkg;

  localparam int BLOCK_W  = 512;
  localparam int DIGEST_W = 160;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Searches req starting at last+1 and
// wrapping modulo NUM_REQ; the first set bit wins.
// Ports:
//   req       in   NUM_REQ          request vector
//   last      in   $clog2(NUM_REQ)  index of the previous winner
//   grant     out  NUM_REQ          one-hot winner (0 when no request)
//   valid     out  1                at least one request is set
//   grant_idx out  $clog2(NUM_REQ)  binary index of the winner
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] w_idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise synthesis infers a latch to hold it.
  always_comb begin
    grant     = '0;
    valid     = 1'b0;
    grant_idx = '0;
    w_idx     = '0;
    // k = 1 is the requester just after the last winner, k = NUM_REQ is the
    // last winner itself, so it only wins again when nobody else asks.
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!valid && req[w_idx]) begin
        valid        = 1'b1;
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/sha1_arbiter.sv
// ----------------------------------------------------------------------------
// sha1_arbiter
// Shares one sha1 compression core between NUM_REQ requesters. A job is a
// single 512-bit block: accept (IDLE) -> core running (RUN) -> response
// handshake (RESP) -> core_on forced low for DRAIN_CYCLES (DRAIN).
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   req_valid/ready/block   requester block handshake (ready is one-hot)
//   rsp_valid/ready         response handshake (valid is one-hot)
//   rsp_digest, rsp_error   shared response payload
//   core_on, core_message   to the sha1 core (both registered)
//   core_digest, core_finish from the sha1 core
//   busy           state is not IDLE
//   grant_id       index of the current or last owner
// ----------------------------------------------------------------------------
module sha1_arbiter
  import sha1_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 400,
  parameter int DRAIN_CYCLES   = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*BLOCK_W-1:0]   req_block,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [DIGEST_W-1:0]          rsp_digest,
  output logic                         rsp_error,
  output logic                         core_on,
  output logic [BLOCK_W-1:0]           core_message,
  input  logic [DIGEST_W-1:0]          core_digest,
  input  logic                         core_finish,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int TIMER_W = $clog2(max_int(TIMEOUT_CYCLES, DRAIN_CYCLES) + 1);

  state_e              r_state, w_state_next;
  logic [TIMER_W-1:0]  r_timer;
  logic                r_core_on;
  logic [BLOCK_W-1:0]  r_core_message;
  logic [DIGEST_W-1:0] r_rsp_digest;
  logic                r_rsp_error;
  logic [IDX_W-1:0]    r_grant_id;
  logic [IDX_W-1:0]    r_last_grant;

  logic [NUM_REQ-1:0]  w_grant;
  logic                w_arb_valid;
  logic [IDX_W-1:0]    w_win_idx;
  logic [BLOCK_W-1:0]  w_block;
  logic                w_accept;
  logic                w_finish;
  logic                w_timeout;
  logic                w_rsp_take;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req       (req_valid),
    .last      (r_last_grant),
    .grant     (w_grant),
    .valid     (w_arb_valid),
    .grant_idx (w_win_idx)
  );

  // Block of the winning requester; only meaningful on the accept cycle.
  always_comb begin
    w_block = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_block = req_block[i*BLOCK_W +: BLOCK_W];
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    w_timeout    = 1'b0;
    w_rsp_take   = 1'b0;
    req_ready    = '0;
    rsp_valid    = '0;
    unique case (r_state)
      IDLE: begin
        req_ready = w_grant;
        if (w_arb_valid) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        // Finish is checked first so it wins over a coincident timeout.
        if (core_finish) begin
          w_finish     = 1'b1;
          w_state_next = RESP;
        end else if (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid[r_grant_id] = 1'b1;
        if (rsp_ready[r_grant_id]) begin
          w_rsp_take   = 1'b1;
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (r_timer == TIMER_W'(DRAIN_CYCLES - 1)) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // NOTE: core_message is a wide datapath register, not a memory; it is reset
  // because the core must never see stale data from before reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer        <= '0;
      r_core_on      <= 1'b0;
      r_core_message <= '0;
      r_rsp_digest   <= '0;
      r_rsp_error    <= 1'b0;
      r_grant_id     <= '0;
      r_last_grant   <= IDX_W'(NUM_REQ - 1);
    end else begin
      if (w_accept) begin
        r_core_message <= w_block;
        r_grant_id     <= w_win_idx;
        r_last_grant   <= w_win_idx;
        r_core_on      <= 1'b1;
        r_timer        <= '0;
      end
      if (r_state == RUN || r_state == DRAIN) r_timer <= r_timer + TIMER_W'(1);
      if (w_finish) begin
        r_rsp_digest <= core_digest;
        r_rsp_error  <= 1'b0;
        r_core_on    <= 1'b0;
      end
      if (w_timeout) begin
        r_rsp_digest <= '0;
        r_rsp_error  <= 1'b1;
        r_core_on    <= 1'b0;
      end
      if (w_rsp_take) r_timer <= '0;
    end
  end

  assign core_on      = r_core_on;
  assign core_message = r_core_message;
  assign rsp_digest   = r_rsp_digest;
  assign rsp_error    = r_rsp_error;
  assign grant_id     = r_grant_id;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_sha1_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sha1_arbiter
// Self-checking bench for sha1_arbiter. A behavioural core stub raises finish
// L cycles after on rises and returns {5{message[31:0]}}. Expectations come
// from a job-level model: round-robin pick over the pending set, latency
// L+2 or TIMEOUT_CYCLES+1 from the accept cycle, and a DRAIN_CYCLES window.
// ----------------------------------------------------------------------------
module tb_sha1_arbiter;
  import sha1_pkg::*;

  localparam int N  = 4;
  localparam int TO = 400;
  localparam int DR = 2;

  typedef logic [BLOCK_W-1:0] val_t;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [N*BLOCK_W-1:0]  req_block;
  logic [N-1:0]          rsp_valid;
  logic [N-1:0]          rsp_ready;
  logic [DIGEST_W-1:0]   rsp_digest;
  logic                  rsp_error;
  logic                  core_on;
  logic [BLOCK_W-1:0]    core_message;
  logic [DIGEST_W-1:0]   core_digest;
  logic                  core_finish;
  logic                  busy;
  logic [$clog2(N)-1:0]  grant_id;

  always #5 clk = ~clk;

  sha1_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO),
    .DRAIN_CYCLES   (DR)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_block    (req_block),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_digest   (rsp_digest),
    .rsp_error    (rsp_error),
    .core_on      (core_on),
    .core_message (core_message),
    .core_digest  (core_digest),
    .core_finish  (core_finish),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  // Core stub: on_cycles is k during the k-th cycle after on rose (0-based).
  int stub_l      = 10;
  bit stub_never  = 1'b0;
  int on_cycles   = 0;
  always @(posedge clk) on_cycles <= core_on ? on_cycles + 1 : 0;
  assign core_finish = core_on && !stub_never && (on_cycles >= stub_l);
  assign core_digest = {5{core_message[31:0]}};

  // Bench state and job-level model.
  int     n_tests = 0;
  int     n_fail  = 0;
  int     multi_hot = 0;
  bit [N-1:0] pend;
  val_t   blk [N];
  int     m_last;
  bit     churn = 1'b0;
  bit     rearm = 1'b0;
  int     dut_grants[$];

  always @(negedge clk) begin
    if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1) multi_hot++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input val_t got, input val_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic val_t rand_block();
    val_t b;
    for (int i = 0; i < BLOCK_W / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic int rr_pick(input bit [N-1:0] p, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (p[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    req_valid = pend;
    for (int i = 0; i < N; i++) req_block[i*BLOCK_W +: BLOCK_W] = blk[i];
  endtask

  task automatic churn_reqs();
    int j;
    if (churn && $urandom_range(0, 3) == 0) begin
      j       = $urandom_range(0, N - 1);
      pend[j] = ~pend[j];
      blk[j]  = rand_block();
      drive_reqs();
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    pend      = '0;
    req_valid = '0;
    req_block = '0;
    rsp_ready = '0;
    #1;
    check("rst_core_on",  val_t'(core_on),      val_t'(0));
    check("rst_core_msg", core_message,         val_t'(0));
    check("rst_rsp_vld",  val_t'(rsp_valid),    val_t'(0));
    check("rst_digest",   val_t'(rsp_digest),   val_t'(0));
    check("rst_error",    val_t'(rsp_error),    val_t'(0));
    check("rst_busy",     val_t'(busy),         val_t'(0));
    check("rst_grant_id", val_t'(grant_id),     val_t'(0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_last  = N - 1;
  endtask

  // Runs one complete job starting from an IDLE negedge; returns at the
  // negedge where the arbiter is IDLE again. hold = cycles rsp_ready is
  // withheld from the owner once the response is up.
  task automatic do_job(input int hold);
    int           win;
    int           n;
    int           bad;
    int           exp_lat;
    logic         exp_err;
    logic [N-1:0] one;
    logic [N-1:0] exp_oh;
    logic [31:0]  r;
    val_t         exp_blk;
    logic [DIGEST_W-1:0] exp_dig;

    drive_reqs();
    #1;
    win = rr_pick(pend, m_last);
    if (win < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL job_setup: got no pending request expected at least one");
      return;
    end
    one    = 1;
    exp_oh = one << win;
    check("req_ready", val_t'(req_ready), val_t'(exp_oh));
    exp_blk = blk[win];
    m_last  = win;

    @(negedge clk);
    if (rearm) blk[win] = rand_block();
    else       pend[win] = 1'b0;
    drive_reqs();
    dut_grants.push_back(int'(grant_id));
    check("grant_id", val_t'(grant_id), val_t'(win));
    check("core_msg", core_message, exp_blk);

    exp_err = stub_never || (stub_l > TO - 1);
    exp_lat = exp_err ? TO + 1 : stub_l + 2;
    n   = 1;
    bad = 0;
    while (rsp_valid == '0 && n < TO + 20) begin
      if (core_on !== 1'b1 || req_ready !== '0) bad++;
      @(negedge clk);
      n++;
    end
    check("rsp_latency", val_t'(n), val_t'(exp_lat));
    check("run_on_held", val_t'(bad), val_t'(0));

    exp_dig = exp_err ? '0 : {5{exp_blk[31:0]}};
    check("rsp_valid",   val_t'(rsp_valid),  val_t'(exp_oh));
    check("rsp_digest",  val_t'(rsp_digest), val_t'(exp_dig));
    check("rsp_error",   val_t'(rsp_error),  val_t'(exp_err));
    check("resp_core_on", val_t'(core_on),   val_t'(0));

    bad = 0;
    for (int h = 0; h < hold; h++) begin
      r         = $urandom;
      rsp_ready = r[N-1:0] & ~exp_oh;
      churn_reqs();
      @(negedge clk);
      if (rsp_valid !== exp_oh || rsp_digest !== exp_dig || rsp_error !== exp_err ||
          core_on !== 1'b0 || req_ready !== '0) bad++;
    end
    check("resp_hold", val_t'(bad), val_t'(0));

    r         = $urandom;
    rsp_ready = exp_oh | r[N-1:0];
    @(negedge clk);
    rsp_ready = '0;
    check("rsp_drop", val_t'(rsp_valid), val_t'(0));

    bad = 0;
    for (int d = 1; d <= DR; d++) begin
      if (busy !== 1'b1 || core_on !== 1'b0 || req_ready !== '0 ||
          rsp_valid !== '0 || rsp_digest !== exp_dig) bad++;
      churn_reqs();
      @(negedge clk);
    end
    check("drain", val_t'(bad), val_t'(0));
    check("idle_after_drain", val_t'(busy), val_t'(0));
  endtask

  initial begin
    int base;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};

    rsp_ready = '0;
    for (int i = 0; i < N; i++) blk[i] = '0;
    do_reset();

    // Quiet after reset: no grant, stays idle.
    repeat (3) @(negedge clk);
    check("idle_no_req", val_t'(req_ready), val_t'(0));
    check("idle_busy",   val_t'(busy),      val_t'(0));

    // Single job on requester 0.
    blk[0]        = rand_block();
    blk[0][31:0]  = 32'h61626380;
    pend          = 4'b0001;
    stub_l        = 170;
    do_job(3);
    check("single_digest", val_t'(rsp_digest), val_t'({5{32'h61626380}}));
    check("single_error",  val_t'(rsp_error),  val_t'(0));

    // All four requesters valid from reset: grant order 0,1,2,3,0.
    do_reset();
    rearm = 1'b1;
    pend  = '1;
    for (int i = 0; i < N; i++) blk[i] = rand_block();
    base = dut_grants.size();
    for (int j = 0; j < 5; j++) begin
      stub_l = $urandom_range(0, 40);
      do_job($urandom_range(0, 2));
    end
    pend  = '0;
    rearm = 1'b0;
    drive_reqs();
    for (int j = 0; j < 5; j++)
      check("rr_order", val_t'(dut_grants[base + j]), val_t'(exp_order[j]));

    // Core never finishes: timeout, then a normal job.
    stub_never = 1'b1;
    pend       = 4'b0010;
    blk[1]     = rand_block();
    do_job(2);
    stub_never = 1'b0;
    stub_l     = 20;
    pend       = 4'b1000;
    blk[3]     = rand_block();
    do_job(1);
    check("after_timeout_err", val_t'(rsp_error), val_t'(0));

    // Back-pressure: response held 50 cycles while requester 2 pends.
    pend   = 4'b0110;
    blk[1] = rand_block();
    blk[2] = rand_block();
    stub_l = 15;
    do_job(50);
    do_job(0);
    check("bp_next_grant", val_t'(dut_grants[dut_grants.size() - 1]), val_t'(2));

    // Reset mid-RUN.
    stub_never = 1'b1;
    pend       = 4'b0100;
    drive_reqs();
    @(negedge clk);
    pend = '0;
    drive_reqs();
    repeat (18) @(negedge clk);
    check("midrun_on", val_t'(core_on), val_t'(1));
    #2 reset_n = 1'b0;
    #1;
    check("async_core_on", val_t'(core_on),   val_t'(0));
    check("async_rsp_vld", val_t'(rsp_valid), val_t'(0));
    check("async_busy",    val_t'(busy),      val_t'(0));
    do_reset();
    stub_never = 1'b0;
    pend       = '1;
    for (int i = 0; i < N; i++) blk[i] = rand_block();
    stub_l = 5;
    do_job(0);
    check("post_reset_grant", val_t'(dut_grants[dut_grants.size() - 1]), val_t'(0));

    // Finish and timeout coincide: finish wins.
    stub_l = TO - 1;
    do_job(1);
    check("tie_error", val_t'(rsp_error), val_t'(0));

    // Randomized jobs with churn on the request lines.
    churn = 1'b1;
    for (int t = 0; t < 25; t++) begin
      int j;
      rearm = 1'($urandom_range(0, 1));
      j       = $urandom_range(0, N - 1);
      pend[j] = 1'b1;
      blk[j]  = rand_block();
      stub_l  = $urandom_range(0, 60);
      if ($urandom_range(0, 9) == 0) stub_l = $urandom_range(395, 420);
      do_job($urandom_range(0, 4));
    end
    churn = 1'b0;
    pend  = '0;
    drive_reqs();
    repeat (2) @(negedge clk);

    check("onehot", val_t'(multi_hot), val_t'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
